// File: rtl/search_ctu_if.sv
//----------------------------------------------------------------------------
// search_ctu_if
// Bundles the search request, memory read-back and memory-control signals
// exchanged between the search control unit and its surroundings.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface search_ctu_if #(
    parameter int A = 8,
    parameter int D = 8
);
    logic         start;
    logic         abort;
    logic [D-1:0] dataRG;
    logic [D-1:0] rdata;
    logic         ce_ctu;
    logic         we_ctu;
    logic [A-1:0] adr_mem2;
    logic         sel_ctu;
    logic         busy;
    logic         done;
    logic         found;
    logic         not_found;
    logic [A-1:0] match_adr;

    // Requester / memory side: issues the search and returns read data
    modport master (
        output start, abort, dataRG, rdata,
        input  ce_ctu, we_ctu, adr_mem2, sel_ctu, busy, done,
        input  found, not_found, match_adr
    );

    // Control-unit side
    modport slave (
        input  start, abort, dataRG, rdata,
        output ce_ctu, we_ctu, adr_mem2, sel_ctu, busy, done,
        output found, not_found, match_adr
    );
endinterface

`default_nettype wire

// File: rtl/search_ctu.sv
//----------------------------------------------------------------------------
// search_ctu
// Linear key-search sequencer. Captures a key on start, takes over the
// memory ce/address path, reads addresses 0..LAST_ADR one per two cycles
// and reports the first matching address or a not-found result.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module search_ctu #(
    parameter int A        = 8,
    parameter int D        = 8,
    parameter int LAST_ADR = 255
) (
    input  wire logic     clk,
    input  wire logic     reset,
    search_ctu_if.slave   bus
);

    localparam logic [1:0]   c_S0       = 2'd0;   // idle
    localparam logic [1:0]   c_S1       = 2'd1;   // issue read
    localparam logic [1:0]   c_S2       = 2'd2;   // compare read data
    localparam logic [1:0]   c_S3       = 2'd3;   // report
    localparam logic [A-1:0] c_LAST_ADR = A'(LAST_ADR);

    logic [1:0]   r_state;
    logic [A-1:0] r_adr_cnt;
    logic [D-1:0] r_key;
    logic [A-1:0] r_match_adr;
    logic         r_found;
    logic         r_not_found;
    logic         r_done;
    logic         r_ce;
    logic         r_sel;
    logic         r_busy;

    logic         w_hit;
    logic         w_end;

    // Decide whether this cycle terminates the search; abort outranks a match
    always_comb begin
        w_hit = 1'b0;
        w_end = 1'b0;
        if (r_state == c_S1) begin
            w_end = bus.abort;
        end else if (r_state == c_S2) begin
            w_hit = !bus.abort && (bus.rdata == r_key);
            w_end = bus.abort || w_hit || (r_adr_cnt == c_LAST_ADR);
        end
    end

    // Search sequencer with registered memory-control and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_S0;
            r_adr_cnt   <= '0;
            r_key       <= '0;
            r_match_adr <= '0;
            r_found     <= 1'b0;
            r_not_found <= 1'b0;
            r_done      <= 1'b0;
            r_ce        <= 1'b0;
            r_sel       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_end) begin
                // Terminate: hand memory back and pulse done from S3
                r_state     <= c_S3;
                r_ce        <= 1'b0;
                r_sel       <= 1'b0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_found     <= w_hit;
                r_not_found <= !w_hit;
                if (w_hit) begin
                    r_match_adr <= r_adr_cnt;
                end
            end else begin
                case (r_state)
                    c_S0: begin
                        if (bus.start) begin
                            r_key       <= bus.dataRG;
                            r_adr_cnt   <= '0;
                            r_found     <= 1'b0;
                            r_not_found <= 1'b0;
                            r_state     <= c_S1;
                            r_ce        <= 1'b1;
                            r_sel       <= 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end
                    c_S1: begin
                        // Read issued this cycle; data arrives during S2
                        r_ce    <= 1'b0;
                        r_state <= c_S2;
                    end
                    c_S2: begin
                        r_adr_cnt <= r_adr_cnt + A'(1);
                        r_ce      <= 1'b1;
                        r_state   <= c_S1;
                    end
                    default: begin
                        r_state <= c_S0;
                    end
                endcase
            end
        end
    end

    assign bus.ce_ctu    = r_ce;
    assign bus.we_ctu    = 1'b0;
    assign bus.adr_mem2  = r_adr_cnt;
    assign bus.sel_ctu   = r_sel;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.found     = r_found;
    assign bus.not_found = r_not_found;
    assign bus.match_adr = r_match_adr;

endmodule

`default_nettype wire

// File: doc/search_ctu.md
Name: search_ctu

Overview:
- Control unit that sequences a linear key search over the data memory.
- On a start request it captures the search key, then takes over the memory ce/we/address path via the existing mux selects.
- Reads addresses 0..LAST_ADR one at a time, compares each read word against the key, and reports found/not-found plus the matching address.
- Sits directly upstream of the memory/address-mux path and replaces the comparator-select glue in the top level.

Parameters:
- A, 8, address width
- D, 8, data width
- LAST_ADR, 255, highest address searched (must be < 2**A)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  search request, sampled only in S0
- abort  input  1  terminate the search in progress
- dataRG  input  D  search key, latched into key_r on accepted start
- rdata  input  D  memory read data (synchronous memory, valid the cycle after ce=1/we=0)
- ce_ctu  output  1  memory enable driven by this unit
- we_ctu  output  1  memory write enable driven by this unit (always 0)
- adr_mem2  output  A  read address to the address mux
- sel_ctu  output  1  1 = ce/we/address muxes take this unit's signals; drives sel_adr, sel_ce_ctu, sel_we_ctu
- busy  output  1  1 in S1/S2
- done  output  1  one-cycle pulse when the search terminates
- found  output  1  key matched (equivalent of q4)
- not_found  output  1  search exhausted or aborted without a match (equivalent of q5)
- match_adr  output  A  address of the first match

Behaviour:
- State encoding: 2 bits. S0=IDLE, S1=READ, S2=CMP, S3=DONE.
- Reset: state=S0, adr_cnt=0, key_r=0, match_adr=0, found=0, not_found=0, done=0, ce_ctu=0, we_ctu=0, sel_ctu=0, busy=0.
- Reset mid-search returns to S0 on that edge; no done pulse is produced.
- S0: ce_ctu=0, sel_ctu=0. Memory belongs to the external ce_in/we_in/adr_mem1 path.
  - start=1: key_r<=dataRG, adr_cnt<=0, found<=0, not_found<=0, go to S1.
  - start=0: found/not_found/match_adr hold their last result.
- S1: ce_ctu=1, we_ctu=0, sel_ctu=1, adr_mem2=adr_cnt. Go to S2.
- S2: ce_ctu=0, sel_ctu=1, adr_mem2=adr_cnt. Priority order:
  - abort: not_found<=1, go to S3.
  - rdata==key_r: found<=1, match_adr<=adr_cnt, go to S3.
  - adr_cnt==LAST_ADR: not_found<=1, go to S3. No wrap to 0.
  - Otherwise: adr_cnt<=adr_cnt+1, go to S1.
- abort is also honoured in S1: go to S3 with not_found<=1. The outstanding read is ignored.
- S3: done=1 for exactly one cycle, sel_ctu=0, ce_ctu=0. Go to S0.
- found and not_found are never both 1. Both are registered outputs.
- Latency: start accepted at edge 0. Address k is issued in S1 at cycle 2k+1 and compared in cycle 2k+2. found and done are visible in cycle 2k+3.
- Full miss completes in 2*(LAST_ADR+1)+1 cycles after start.
- start while busy or in S3 is ignored. dataRG changes after capture do not affect the search.
- abort in S0/S3 is ignored.
- Simultaneous match and abort in S2: abort wins.
- Duplicate keys: the lowest address is reported.

Test Plan:
- Preload mem[0..255]=addr^8'hFF; dataRG=8'hFC, pulse start -> found=1, match_adr=8'h03, done 9 cycles after start, not_found=0.
- Same memory; dataRG=8'hFF -> match at address 0: found=1, match_adr=0, done at cycle 3.
- Key absent (all words 8'h00, key 8'h5A) -> not_found=1 and done at cycle 513; adr_mem2 never exceeds 8'hFF; sel_ctu=1 for cycles 1..512 only.
- mem[7]=mem[9]=8'hA5, key 8'hA5; change dataRG to 8'h00 one cycle after start -> found, match_adr=7.
- Start search; assert abort in cycle 6 (S2, adr 2) -> not_found=1, done next cycle; repeated start during busy is ignored; a new start afterwards clears not_found.
- Assert reset in cycle 5 of a search -> next cycle state S0, all outputs 0, no done pulse; external write via ce_in/we_in succeeds afterwards.
